// File: rtl/mem_access_ctrl.sv
// MEM-stage data-memory initiator for the LC-3b pipeline.
// Turns LDR/LDB/STR/STB/LDI/STI into registered data-cache requests, holds the
// pipeline while an access is outstanding and hands load data to WB.
module mem_access_ctrl #(
    parameter int CNT_WIDTH = 16
) (
    input  logic                 clk,
    input  logic                 rst_n,
    input  logic                 mem_valid_in,
    input  logic [2:0]           mem_op,
    input  logic [15:0]          mem_address,
    input  logic [15:0]          mem_wdata,
    output logic                 dmem_read,
    output logic                 dmem_write,
    output logic [15:0]          dmem_address,
    output logic [15:0]          dmem_wdata,
    output logic [1:0]           dmem_byte_enable,
    input  logic [15:0]          dmem_rdata,
    input  logic                 dmem_resp,
    output logic                 mem_stall,
    output logic [15:0]          mem_rdata,
    output logic                 mem_rdata_valid,
    output logic [CNT_WIDTH-1:0] stall_count
);

    localparam logic [2:0] OP_NONE = 3'd0;
    localparam logic [2:0] OP_LDR  = 3'd1;
    localparam logic [2:0] OP_LDB  = 3'd2;
    localparam logic [2:0] OP_STR  = 3'd3;
    localparam logic [2:0] OP_STB  = 3'd4;
    localparam logic [2:0] OP_LDI  = 3'd5;
    localparam logic [2:0] OP_STI  = 3'd6;
    localparam logic [2:0] OP_NOP7 = 3'd7;

    typedef enum logic [1:0] {IDLE = 2'd0, ACC1 = 2'd1, ACC2 = 2'd2, DONE = 2'd3} state_t;

    state_t                state_reg, state_next;
    logic [2:0]            op_reg, op_next;
    logic                  byte_sel_reg, byte_sel_next;
    logic                  read_reg, read_next;
    logic                  write_reg, write_next;
    logic [15:0]           address_reg, address_next;
    logic [15:0]           wdata_reg, wdata_next;
    logic [1:0]            be_reg, be_next;
    logic [15:0]           rdata_reg, rdata_next;
    logic [CNT_WIDTH-1:0]  count_reg, count_next;

    logic                  op_valid;
    logic                  accept;
    logic                  is_load;
    logic [15:0]           stb_wdata;
    logic [7:0]            ld_byte;
    logic [15:0]           ldb_data;

    // A store byte is driven on both lanes; byte_enable picks the lane that lands.
    genvar gi;
    generate
        for (gi = 0; gi < 2; gi++) begin : g_stb_lane
            assign stb_wdata[gi*8 +: 8] = mem_wdata[7:0];
        end
    endgenerate

    assign ld_byte  = byte_sel_reg ? dmem_rdata[15:8] : dmem_rdata[7:0];
    assign ldb_data = {{8{ld_byte[7]}}, ld_byte};

    assign op_valid = (mem_op != OP_NONE) && (mem_op != OP_NOP7);
    assign accept   = (state_reg == IDLE) && mem_valid_in && op_valid;
    assign is_load  = (op_reg == OP_LDR) || (op_reg == OP_LDB) || (op_reg == OP_LDI);

    assign mem_stall        = accept || (state_reg == ACC1) || (state_reg == ACC2);
    assign mem_rdata_valid  = (state_reg == DONE) && is_load;
    assign dmem_read        = read_reg;
    assign dmem_write       = write_reg;
    assign dmem_address     = address_reg;
    assign dmem_wdata       = wdata_reg;
    assign dmem_byte_enable = be_reg;
    assign mem_rdata        = rdata_reg;
    assign stall_count      = count_reg;

    // State and registered request/result; reset drops any outstanding request at once.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state_reg    <= IDLE;
            op_reg       <= OP_NONE;
            byte_sel_reg <= 1'b0;
            read_reg     <= 1'b0;
            write_reg    <= 1'b0;
            address_reg  <= 16'h0000;
            wdata_reg    <= 16'h0000;
            be_reg       <= 2'b00;
            rdata_reg    <= 16'h0000;
            count_reg    <= '0;
        end else begin
            state_reg    <= state_next;
            op_reg       <= op_next;
            byte_sel_reg <= byte_sel_next;
            read_reg     <= read_next;
            write_reg    <= write_next;
            address_reg  <= address_next;
            wdata_reg    <= wdata_next;
            be_reg       <= be_next;
            rdata_reg    <= rdata_next;
            count_reg    <= count_next;
        end
    end

    // Next-state, next request and load-result selection.
    always_comb begin
        state_next    = state_reg;
        op_next       = op_reg;
        byte_sel_next = byte_sel_reg;
        read_next     = read_reg;
        write_next    = write_reg;
        address_next  = address_reg;
        wdata_next    = wdata_reg;
        be_next       = be_reg;
        rdata_next    = rdata_reg;
        count_next    = (mem_stall && !(&count_reg)) ? count_reg + 1'b1 : count_reg;

        case (state_reg)
            IDLE: begin
                if (accept) begin
                    state_next    = ACC1;
                    op_next       = mem_op;
                    byte_sel_next = mem_address[0];
                    wdata_next    = mem_wdata;
                    address_next  = {mem_address[15:1], 1'b0};
                    read_next     = 1'b0;
                    write_next    = 1'b0;
                    be_next       = 2'b00;
                    case (mem_op)
                        OP_LDR: begin
                            read_next = 1'b1;
                            be_next   = 2'b11;
                        end
                        OP_LDB: begin
                            read_next    = 1'b1;
                            address_next = mem_address;
                        end
                        OP_STR: begin
                            write_next = 1'b1;
                            be_next    = 2'b11;
                        end
                        OP_STB: begin
                            write_next   = 1'b1;
                            address_next = mem_address;
                            wdata_next   = stb_wdata;
                            be_next      = mem_address[0] ? 2'b10 : 2'b01;
                        end
                        default: begin
                            // LDI/STI: first access always reads the pointer word.
                            read_next = 1'b1;
                        end
                    endcase
                end
            end
            ACC1: begin
                if (dmem_resp) begin
                    if ((op_reg == OP_LDI) || (op_reg == OP_STI)) begin
                        state_next   = ACC2;
                        address_next = {dmem_rdata[15:1], 1'b0};
                        be_next      = 2'b11;
                        read_next    = (op_reg == OP_LDI);
                        write_next   = (op_reg == OP_STI);
                    end else begin
                        state_next = DONE;
                        read_next  = 1'b0;
                        write_next = 1'b0;
                        if (op_reg == OP_LDR) begin
                            rdata_next = dmem_rdata;
                        end else if (op_reg == OP_LDB) begin
                            rdata_next = ldb_data;
                        end
                    end
                end
            end
            ACC2: begin
                if (dmem_resp) begin
                    state_next = DONE;
                    read_next  = 1'b0;
                    write_next = 1'b0;
                    if (op_reg == OP_LDI) begin
                        rdata_next = dmem_rdata;
                    end
                end
            end
            default: begin
                state_next = IDLE;
            end
        endcase
    end

endmodule
